// File: rtl/shifterPkg.sv
// Operation encoding shared by the shift unit and its issue logic.
package shifterPkg;
    typedef enum logic [2:0] {
        SHL = 3'd0,
        SHR = 3'd1,
        SAR = 3'd2,
        ROL = 3'd3,
        ROR = 3'd4,
        RCL = 3'd5,
        RCR = 3'd6
    } shiftOpSel;
endpackage

// File: rtl/shift_pipe_if.sv
// Issue-side and writeback-side handshake bundle of the shift unit.
interface shift_pipe_if;
    import shifterPkg::*;

    logic        in_valid;
    logic        in_ready;
    shiftOpSel   in_op;
    logic [31:0] in_data;
    logic [5:0]  in_count;
    logic        in_carry;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_carry;
    logic        out_zero;
    logic        out_sign;

    modport master (
        output in_valid, in_op, in_data, in_count, in_carry, out_ready,
        input  in_ready, out_valid, out_data, out_carry, out_zero, out_sign
    );

    modport slave (
        input  in_valid, in_op, in_data, in_count, in_carry, out_ready,
        output in_ready, out_valid, out_data, out_carry, out_zero, out_sign
    );
endinterface

// File: rtl/shift_pipe.sv
// Two-stage shift/rotate unit: shift by 1/2/4 in stage A, by 8/16 in stage B, then flags.
// Latency 2 cycles; writeback stall holds both stages and drops in_ready once stage A is full.
module shift_pipe
    import shifterPkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic         clk,
    input  logic         reset,
    shift_pipe_if.slave  bus
);

    logic              adv_b;
    logic              accept;
    shiftOpSel         op_n;
    logic [4:0]        n;
    logic [CNTW-1:0]   cnt_mod;
    logic [32:0]       s1, s2, s4, s8, s16;

    logic              valid_a;
    shiftOpSel         op_a;
    logic [1:0]        hi_a;
    logic [WIDTH-1:0]  data_a;
    logic              carry_a;

    // One power-of-two step; result is {carry, data}. Through-carry rotates treat {c,d} as 33 bits.
    function automatic logic [32:0] step(input shiftOpSel op, input logic [31:0] d,
                                         input logic c, input logic [4:0] k);
        logic [32:0] v;
        logic [31:0] r;
        v    = {c, d};
        r    = '0;
        step = 'x;
        case (op)
            SHL: step = {d[5'd0 - k], d << k};
            SHR: step = {d[k - 5'd1], d >> k};
            SAR: begin
                r    = $signed(d) >>> k;
                step = {d[k - 5'd1], r};
            end
            ROL: begin
                r    = (d << k) | (d >> (6'd32 - {1'b0, k}));
                step = {r[0], r};
            end
            ROR: begin
                r    = (d >> k) | (d << (6'd32 - {1'b0, k}));
                step = {r[31], r};
            end
            RCL:     step = (v << k) | (v >> (6'd33 - {1'b0, k}));
            RCR:     step = (v >> k) | (v << (6'd33 - {1'b0, k}));
            default: step = 'x;
        endcase
    endfunction

    assign adv_b       = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = !valid_a || adv_b;
    assign accept      = bus.in_valid && bus.in_ready;

    // A 33-bit rotate by 32 is a rotate the other way by 1, keeping n within 5 bits.
    always_comb begin
        op_n    = bus.in_op;
        cnt_mod = bus.in_count;
        n       = bus.in_count[4:0];
        if (bus.in_op == RCL || bus.in_op == RCR) begin
            cnt_mod = (bus.in_count >= 6'd33) ? bus.in_count - 6'd33 : bus.in_count;
            n       = cnt_mod[4:0];
            if (cnt_mod == 6'd32) begin
                op_n = (bus.in_op == RCL) ? RCR : RCL;
                n    = 5'd1;
            end
        end
    end

    always_comb begin
        s1  = n[0]    ? step(op_n, bus.in_data, bus.in_carry, 5'd1) : {bus.in_carry, bus.in_data};
        s2  = n[1]    ? step(op_n, s1[31:0], s1[32], 5'd2)          : s1;
        s4  = n[2]    ? step(op_n, s2[31:0], s2[32], 5'd4)          : s2;
        s8  = hi_a[0] ? step(op_a, data_a, carry_a, 5'd8)           : {carry_a, data_a};
        s16 = hi_a[1] ? step(op_a, s8[31:0], s8[32], 5'd16)         : s8;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_a <= 1'b0;
            op_a    <= SHL;
            hi_a    <= '0;
            data_a  <= '0;
            carry_a <= 1'b0;
        end else begin
            if (bus.in_ready) valid_a <= bus.in_valid;
            if (accept) begin
                op_a    <= op_n;
                hi_a    <= n[4:3];
                data_a  <= s4[31:0];
                carry_a <= s4[32];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_carry <= 1'b0;
            bus.out_zero  <= 1'b0;
            bus.out_sign  <= 1'b0;
        end else if (adv_b) begin
            bus.out_valid <= valid_a;
            if (valid_a) begin
                bus.out_data  <= s16[31:0];
                bus.out_carry <= s16[32];
                bus.out_zero  <= (s16[31:0] == 32'd0);
                bus.out_sign  <= s16[31];
            end
        end
    end

    a_legal_op: assert property (@(posedge clk) disable iff (reset)
        bus.in_valid |-> (bus.in_op inside {SHL, SHR, SAR, ROL, ROR, RCL, RCR}));

endmodule
